fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Parametrised fetch-1 PC generator: owns the fetch PC, picks next PC from redirects, BTB/BP hits
//  across FETCH_WIDTH slots, RAS and sequential fetch. Adds an I-cache miss-wait FSM and a
//  valid/ready output register toward fetch-2. BTB, BP, RAS and L1I stay external.
// PARAMETERS
//  SIZE_PC      32  PC width in bits
//  FETCH_WIDTH  4   instruction slots per bundle (power of 2, 2..8)
//  INST_BYTES   8   bytes per instruction slot
//  LINE_BYTES   64  I-cache line size (>= FETCH_WIDTH*INST_BYTES; used only with FETCH_ALIGN_EN)
// PORTS
//  clk              in   1              clock
//  reset            in   1              synchronous, active-high reset
//  recoverFlag_i    in   1              commit recovery (highest priority)
//  recoverPC_i      in   SIZE_PC        recovery target
//  exceptionFlag_i  in   1              exception redirect
//  exceptionPC_i    in   SIZE_PC        exception target
//  flagRecoverEX_i  in   1              EX-stage mispredict
//  targetAddrEX_i   in   SIZE_PC        EX target
//  flagRecoverID_i  in   1              ID-stage mispredict
//  flagRtrID_i      in   1              ID redirect is a return: use rasTopCP_i
//  targetAddrID_i   in   SIZE_PC        ID target
//  btbHit_i         in   FETCH_WIDTH    per-slot BTB hit
//  btbType_i        in   2*FETCH_WIDTH  per-slot type: 00 ret, 01 call, 10 jump, 11 cond
//  btbTarget_i      in   FETCH_WIDTH*SIZE_PC per-slot target
//  predDir_i        in   FETCH_WIDTH    per-slot direction prediction
//  rasTop_i         in   SIZE_PC        RAS top; rasTopCP_i in SIZE_PC: checkpointed top
//  icMiss_i         in   1              L1I miss for current PC
//  icRefill_i       in   1              refill complete pulse
//  fetchReady_i     in   1              fetch-2 accepts bundle
//  fetchValid_o     out  1              bundle valid
//  fetchPC_o        out  SIZE_PC        bundle start PC
//  fetchMask_o      out  FETCH_WIDTH    valid slots in bundle
//  takenSlot_o      out  log2(FW)+1     index of taken slot; MSB=1 means none taken
//  pc_o             out  SIZE_PC        current fetch PC (to BTB/BP/L1I)
//  rasPush_o/rasPushAddr_o/rasPop_o out 1/SIZE_PC/1  RAS control, qualified by fire
// BEHAVIOUR
//  - Reset: PC=0, state RUN, fetchValid_o=0, fetchPC_o=0, fetchMask_o=0, takenSlot_o=none; RAS ctls 0.
//  - Slot taken: hit[k] & (pred[k] | type[k]!=11). Slot k counts only if in window (see CONFIG).
//  - Next-PC priority: recoverFlag > exceptionFlag > flagRecoverEX > flagRecoverID
//    (rtr ? rasTopCP : targetAddrID) > first taken slot (type 00 ? rasTop : target) > sequential.
//  - fire = state==RUN & ~icMiss_i & (~fetchValid_o | fetchReady_i). On fire: PC<=nextPC,
//    output reg loads {PC, mask up to and incl. taken slot, takenSlot}; 1-cycle latency PC->bundle.
//  - No fire, no redirect: PC and output reg hold; fetchValid_o clears only when fetchReady_i.
//  - Any redirect (4 sources): PC<=target same edge, fetchValid_o<=0 (bundle squashed), state<=RUN,
//    regardless of stall/miss; RAS push/pop suppressed that cycle.
//  - FSM RUN->MISS_WAIT when state RUN & icMiss_i (no fire). MISS_WAIT->RUN on icRefill_i;
//    PC unchanged, refetch next cycle. Redirect in MISS_WAIT aborts wait.
//  - RAS: on fire, taken slot type 01 -> rasPush_o=1, rasPushAddr_o=PC+(k+1)*INST_BYTES
//    (every slot incl. last); type 00 -> rasPop_o=1. Never both.
//  - PC arithmetic modulo 2^SIZE_PC; wrap at top silently.
// CONFIGURATION
//  FETCH_ALIGN_EN defined: window = slots from PC offset in line to line end, capped at FETCH_WIDTH;
//    sequential nextPC = min(PC+FW*INST_BYTES, next line base); mask excludes slots past line end.
//  Undefined: window = all FETCH_WIDTH slots; sequential nextPC = PC+FETCH_WIDTH*INST_BYTES.
// STRUCTURE
//  fetch_pkg: SIZE_PC, branch type enum (BR_RET/CALL/JMP/COND), fsm state enum, clog2 helper.
//  Sub-module fetch_slot_select: combinational first-taken priority encoder over FETCH_WIDTH
//  slots -> takenSlot, mask, selected target. Top holds PC reg, FSM, output reg, RAS ctl.
// TESTING
//  1 Reset, no hits, ready=1 -> fetchPC_o 0,0x20,0x40; mask=1111, takenSlot none (FW=4).
//  2 PC=0x100, slot2 cond hit pred=1 target 0x400 -> mask=0111, taken=2, next PC 0x400.
//  3 PC=0x200, slot3 call target 0x800 -> rasPush_o=1, rasPushAddr_o=0x220; slot1 ret -> pop, PC=rasTop_i.
//  4 icMiss_i 3 cycles then icRefill_i -> no fire, fetchValid_o holds/clears, same PC refetched.
//  5 recoverFlag_i & flagRecoverEX_i same cycle, fetchReady_i=0 -> PC=recoverPC_i, fetchValid_o=0.
//  6 FETCH_ALIGN_EN, LINE 64, PC=0x130 -> mask=0011, next PC 0x140.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared PC width, branch/FSM enums and a constant clog2 helper for the fetch-1 PC generator.
package fetch_pkg;
  localparam int SIZE_PC = 32;
  typedef enum logic [1:0] {BR_RET = 2'b00, BR_CALL = 2'b01, BR_JMP = 2'b10, BR_COND = 2'b11} br_type_e;
  typedef enum logic {ST_RUN = 1'b0, ST_MISS_WAIT = 1'b1} fsm_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fetch_slot_select.sv
// fetch_slot_select: first-taken priority encoder over the bundle slots -> taken slot, mask, target.
module fetch_slot_select
  import fetch_pkg::*;
#(
  parameter int FW = 4,
  parameter int PCW = 32,
  localparam int TW = clog2(FW) + 1
) (
  input  logic [FW-1:0]     hit_i,
  input  logic [2*FW-1:0]   type_i,
  input  logic [FW*PCW-1:0] target_i,
  input  logic [FW-1:0]     pred_i,
  input  logic [FW-1:0]     win_i,
  input  logic [PCW-1:0]    ras_top_i,
  output logic              taken_o,
  output logic [TW-1:0]     slot_o,
  output logic [FW-1:0]     mask_o,
  output logic [PCW-1:0]    target_o,
  output br_type_e          type_o
);
  always_comb begin
    taken_o = 1'b0;
    slot_o = {1'b1, {(TW-1){1'b0}}};
    mask_o = win_i;
    target_o = '0;
    type_o = BR_COND;
    // Descending scan so the lowest taken slot is the one left standing.
    for (int k = FW - 1; k >= 0; k--)
      if (win_i[k] && hit_i[k] && (pred_i[k] || type_i[2*k+:2] != BR_COND)) begin
        taken_o = 1'b1;
        slot_o = TW'(k);
        mask_o = {FW{1'b1}} >> (FW - 1 - k);
        type_o = br_type_e'(type_i[2*k+:2]);
        target_o = (type_i[2*k+:2] == BR_RET) ? ras_top_i : target_i[k*PCW+:PCW];
      end
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch-1 PC register, redirect/branch next-PC select, I-cache miss FSM and bundle output reg.
// FETCH_ALIGN_EN: when defined, bundles stop at the I-cache line end.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int SIZE_PC = fetch_pkg::SIZE_PC,
  parameter int FETCH_WIDTH = 4,
  parameter int INST_BYTES = 8,
  parameter int LINE_BYTES = 64,
  localparam int TW = clog2(FETCH_WIDTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recoverFlag_i,
  input  logic [SIZE_PC-1:0]             recoverPC_i,
  input  logic                           exceptionFlag_i,
  input  logic [SIZE_PC-1:0]             exceptionPC_i,
  input  logic                           flagRecoverEX_i,
  input  logic [SIZE_PC-1:0]             targetAddrEX_i,
  input  logic                           flagRecoverID_i,
  input  logic                           flagRtrID_i,
  input  logic [SIZE_PC-1:0]             targetAddrID_i,
  input  logic [FETCH_WIDTH-1:0]         btbHit_i,
  input  logic [2*FETCH_WIDTH-1:0]       btbType_i,
  input  logic [FETCH_WIDTH*SIZE_PC-1:0] btbTarget_i,
  input  logic [FETCH_WIDTH-1:0]         predDir_i,
  input  logic [SIZE_PC-1:0]             rasTop_i,
  input  logic [SIZE_PC-1:0]             rasTopCP_i,
  input  logic                           icMiss_i,
  input  logic                           icRefill_i,
  input  logic                           fetchReady_i,
  output logic                           fetchValid_o,
  output logic [SIZE_PC-1:0]             fetchPC_o,
  output logic [FETCH_WIDTH-1:0]         fetchMask_o,
  output logic [TW-1:0]                  takenSlot_o,
  output logic [SIZE_PC-1:0]             pc_o,
  output logic                           rasPush_o,
  output logic [SIZE_PC-1:0]             rasPushAddr_o,
  output logic                           rasPop_o
);
  logic [SIZE_PC-1:0] pc_q, pc_d, fpc_q, fpc_d, paddr_q, paddr_d, seq_pc, redir_pc, sel_tgt;
  logic [FETCH_WIDTH-1:0] win, mask_q, mask_d, sel_mask;
  logic [TW-1:0] slot_q, slot_d, sel_slot;
  logic valid_q, valid_d, push_q, push_d, pop_q, pop_d, redirect, fire, load, taken;
  fsm_e state_q, state_d;
  br_type_e sel_type;
`ifdef FETCH_ALIGN_EN
  logic [SIZE_PC-1:0] line_end, n_slots;
  always_comb begin
    line_end = (pc_q & ~SIZE_PC'(LINE_BYTES - 1)) + SIZE_PC'(LINE_BYTES);
    n_slots = (line_end - pc_q) / SIZE_PC'(INST_BYTES);
    win = (n_slots >= SIZE_PC'(FETCH_WIDTH)) ? {FETCH_WIDTH{1'b1}}
        : {FETCH_WIDTH{1'b1}} >> (SIZE_PC'(FETCH_WIDTH) - n_slots);
    seq_pc = (n_slots >= SIZE_PC'(FETCH_WIDTH)) ? pc_q + SIZE_PC'(FETCH_WIDTH * INST_BYTES) : line_end;
  end
`else
  assign win = {FETCH_WIDTH{1'b1}};
  assign seq_pc = pc_q + SIZE_PC'(FETCH_WIDTH * INST_BYTES);
`endif
  fetch_slot_select #(.FW(FETCH_WIDTH), .PCW(SIZE_PC)) u_sel (
    .hit_i(btbHit_i), .type_i(btbType_i), .target_i(btbTarget_i), .pred_i(predDir_i),
    .win_i(win), .ras_top_i(rasTop_i), .taken_o(taken), .slot_o(sel_slot),
    .mask_o(sel_mask), .target_o(sel_tgt), .type_o(sel_type)
  );
  always_comb begin
    redirect = recoverFlag_i | exceptionFlag_i | flagRecoverEX_i | flagRecoverID_i;
    redir_pc = recoverFlag_i ? recoverPC_i : exceptionFlag_i ? exceptionPC_i
             : flagRecoverEX_i ? targetAddrEX_i : flagRtrID_i ? rasTopCP_i : targetAddrID_i;
    fire = (state_q == ST_RUN) & ~icMiss_i & (~valid_q | fetchReady_i);
    load = fire & ~redirect;
    pc_d = redirect ? redir_pc : load ? (taken ? sel_tgt : seq_pc) : pc_q;
    state_d = redirect ? ST_RUN : (state_q == ST_RUN) ? (icMiss_i ? ST_MISS_WAIT : ST_RUN)
            : (icRefill_i ? ST_RUN : ST_MISS_WAIT);
    valid_d = redirect ? 1'b0 : load ? 1'b1 : valid_q & ~fetchReady_i;
    fpc_d = load ? pc_q : fpc_q;
    mask_d = load ? sel_mask : mask_q;
    slot_d = load ? sel_slot : slot_q;
    push_d = load & taken & (sel_type == BR_CALL);
    pop_d = load & taken & (sel_type == BR_RET);
    paddr_d = push_d ? pc_q + SIZE_PC'((int'(sel_slot[TW-2:0]) + 1) * INST_BYTES) : paddr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      fpc_q <= '0;
      mask_q <= '0;
      slot_q <= {1'b1, {(TW-1){1'b0}}};
      push_q <= 1'b0;
      pop_q <= 1'b0;
      paddr_q <= '0;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
      valid_q <= valid_d;
      fpc_q <= fpc_d;
      mask_q <= mask_d;
      slot_q <= slot_d;
      push_q <= push_d;
      pop_q <= pop_d;
      paddr_q <= paddr_d;
    end
  end
  assign pc_o = pc_q;
  assign fetchValid_o = valid_q;
  assign fetchPC_o = fpc_q;
  assign fetchMask_o = mask_q;
  assign takenSlot_o = slot_q;
  assign rasPush_o = push_q;
  assign rasPushAddr_o = paddr_q;
  assign rasPop_o = pop_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed bench for fetch_pc_gen with a cycle-level reference model and literal checks.
module tb_fetch_pc_gen;
  localparam int FW = 4;
  localparam int IB = 8;
  localparam int LINE = 64;
  localparam logic [2:0] NONE = 3'b100;
  logic clk = 1'b0, reset = 1'b1;
  logic recoverFlag_i, exceptionFlag_i, flagRecoverEX_i, flagRecoverID_i, flagRtrID_i;
  logic [31:0] recoverPC_i, exceptionPC_i, targetAddrEX_i, targetAddrID_i, rasTop_i, rasTopCP_i;
  logic [FW-1:0] btbHit_i, predDir_i;
  logic [2*FW-1:0] btbType_i;
  logic [FW*32-1:0] btbTarget_i;
  logic icMiss_i, icRefill_i, fetchReady_i;
  logic fetchValid_o, rasPush_o, rasPop_o;
  logic [31:0] fetchPC_o, pc_o, rasPushAddr_o;
  logic [FW-1:0] fetchMask_o;
  logic [2:0] takenSlot_o;
  int tests = 0, fails = 0;
  fetch_pc_gen #(.SIZE_PC(32), .FETCH_WIDTH(FW), .INST_BYTES(IB), .LINE_BYTES(LINE)) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i), .recoverPC_i(recoverPC_i),
    .exceptionFlag_i(exceptionFlag_i), .exceptionPC_i(exceptionPC_i),
    .flagRecoverEX_i(flagRecoverEX_i), .targetAddrEX_i(targetAddrEX_i),
    .flagRecoverID_i(flagRecoverID_i), .flagRtrID_i(flagRtrID_i), .targetAddrID_i(targetAddrID_i),
    .btbHit_i(btbHit_i), .btbType_i(btbType_i), .btbTarget_i(btbTarget_i), .predDir_i(predDir_i),
    .rasTop_i(rasTop_i), .rasTopCP_i(rasTopCP_i), .icMiss_i(icMiss_i), .icRefill_i(icRefill_i),
    .fetchReady_i(fetchReady_i), .fetchValid_o(fetchValid_o), .fetchPC_o(fetchPC_o),
    .fetchMask_o(fetchMask_o), .takenSlot_o(takenSlot_o), .pc_o(pc_o), .rasPush_o(rasPush_o),
    .rasPushAddr_o(rasPushAddr_o), .rasPop_o(rasPop_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: what fetch-1 should have done on each edge, from the rules in plain arithmetic.
  logic [31:0] m_pc, m_fpc, m_paddr;
  logic m_wait, m_valid, m_push, m_pop, m_seen = 1'b0, m_fire, m_redir;
  logic [FW-1:0] m_mask;
  logic [2:0] m_slot;
  logic [31:0] m_rpc;
  int nwin, tk;
  logic [1:0] ty;
  always @(posedge clk) begin
    m_seen = 1'b1;
    if (reset) begin
      m_pc = 0; m_wait = 0; m_valid = 0; m_fpc = 0; m_mask = 0; m_slot = NONE;
      m_push = 0; m_pop = 0; m_paddr = 0;
    end else begin
      nwin = FW;
`ifdef FETCH_ALIGN_EN
      nwin = int'((LINE - (m_pc % LINE)) / IB);
      if (nwin > FW) nwin = FW;
`endif
      tk = -1;
      for (int k = 0; k < nwin; k++)
        if (tk < 0 && btbHit_i[k] && (predDir_i[k] || btbType_i[2*k+:2] != 2'b11)) tk = k;
      m_redir = recoverFlag_i || exceptionFlag_i || flagRecoverEX_i || flagRecoverID_i;
      if (recoverFlag_i) m_rpc = recoverPC_i;
      else if (exceptionFlag_i) m_rpc = exceptionPC_i;
      else if (flagRecoverEX_i) m_rpc = targetAddrEX_i;
      else m_rpc = flagRtrID_i ? rasTopCP_i : targetAddrID_i;
      m_fire = !m_wait && !icMiss_i && (!m_valid || fetchReady_i);
      m_push = 0; m_pop = 0;
      if (m_redir) begin
        m_pc = m_rpc; m_valid = 0; m_wait = 0;
      end else begin
        if (m_fire) begin
          m_fpc = m_pc; m_valid = 1;
          if (tk < 0) begin
            m_mask = FW'((1 << nwin) - 1); m_slot = NONE; m_pc = m_pc + 32'(nwin * IB);
          end else begin
            ty = btbType_i[2*tk+:2];
            m_mask = FW'((1 << (tk + 1)) - 1); m_slot = 3'(tk);
            if (ty == 2'b01) begin m_push = 1; m_paddr = m_pc + 32'((tk + 1) * IB); end
            m_pop = (ty == 2'b00);
            m_pc = (ty == 2'b00) ? rasTop_i : btbTarget_i[32*tk+:32];
          end
        end else if (fetchReady_i) m_valid = 0;
        if (!m_wait && icMiss_i) m_wait = 1;
        else if (m_wait && icRefill_i) m_wait = 0;
      end
    end
  end
  always @(negedge clk) if (m_seen) begin
    chk("m_pc", pc_o, m_pc);
    chk("m_valid", fetchValid_o, m_valid);
    chk("m_fpc", fetchPC_o, m_fpc);
    chk("m_mask", fetchMask_o, m_mask);
    chk("m_slot", takenSlot_o, m_slot);
    chk("m_push", rasPush_o, m_push);
    chk("m_pop", rasPop_o, m_pop);
    chk("m_paddr", rasPushAddr_o, m_paddr);
  end
  task automatic tick(); @(negedge clk); endtask
  task automatic clr_hits();
    btbHit_i = 0; btbType_i = 0; btbTarget_i = 0; predDir_i = 0;
  endtask
  task automatic clr_redir();
    recoverFlag_i = 0; exceptionFlag_i = 0; flagRecoverEX_i = 0; flagRecoverID_i = 0; flagRtrID_i = 0;
  endtask
  task automatic set_slot(input int k, input logic [1:0] t, input logic [31:0] tg, input logic pr);
    btbHit_i[k] = 1'b1; btbType_i[2*k+:2] = t; btbTarget_i[32*k+:32] = tg; predDir_i[k] = pr;
  endtask
  task automatic recover(input logic [31:0] a);
    recoverFlag_i = 1; recoverPC_i = a; tick(); clr_redir();
  endtask
  initial begin
    clr_hits(); clr_redir();
    recoverPC_i = 0; exceptionPC_i = 0; targetAddrEX_i = 0; targetAddrID_i = 0;
    rasTop_i = 0; rasTopCP_i = 0; icMiss_i = 0; icRefill_i = 0; fetchReady_i = 1;
    repeat (3) tick();
    chk("rst_valid", fetchValid_o, 0); chk("rst_fpc", fetchPC_o, 0); chk("rst_mask", fetchMask_o, 0);
    chk("rst_slot", takenSlot_o, NONE); chk("rst_pc", pc_o, 0); chk("rst_ras", {rasPush_o, rasPop_o}, 0);
    reset = 0;
    tick(); chk("seq0_fpc", fetchPC_o, 0); chk("seq0_mask", fetchMask_o, 4'hf); chk("seq0_pc", pc_o, 32'h20);
    tick(); chk("seq1_fpc", fetchPC_o, 32'h20);
    tick(); chk("seq2_fpc", fetchPC_o, 32'h40); chk("seq2_slot", takenSlot_o, NONE);
    recover(32'h100); chk("redir_valid", fetchValid_o, 0); chk("redir_pc", pc_o, 32'h100);
    set_slot(2, 2'b11, 32'h400, 1);
    tick(); chk("cond_mask", fetchMask_o, 4'b0111); chk("cond_slot", takenSlot_o, 2); chk("cond_pc", pc_o, 32'h400);
    clr_hits(); recover(32'h200);
    set_slot(0, 2'b11, 32'h1111, 0); set_slot(3, 2'b01, 32'h800, 0);
    tick(); chk("call_push", rasPush_o, 1); chk("call_addr", rasPushAddr_o, 32'h220);
    chk("call_pc", pc_o, 32'h800); chk("call_slot", takenSlot_o, 3);
    clr_hits(); set_slot(1, 2'b00, 32'h9999, 0); rasTop_i = 32'h5000;
    tick(); chk("ret_pop", rasPop_o, 1); chk("ret_push", rasPush_o, 0);
    chk("ret_pc", pc_o, 32'h5000); chk("ret_mask", fetchMask_o, 4'b0011);
    clr_hits();
    fetchReady_i = 0; icMiss_i = 1;
    tick(); chk("miss_hold_valid", fetchValid_o, 1); chk("miss_hold_fpc", fetchPC_o, 32'h800);
    fetchReady_i = 1;
    tick(); chk("miss_clr_valid", fetchValid_o, 0);
    tick(); chk("miss_pc", pc_o, 32'h5000);
    icMiss_i = 0; icRefill_i = 1;
    tick(); chk("refill_valid", fetchValid_o, 0); chk("refill_pc", pc_o, 32'h5000);
    icRefill_i = 0;
    tick(); chk("refetch_fpc", fetchPC_o, 32'h5000); chk("refetch_valid", fetchValid_o, 1);
    fetchReady_i = 0; recoverFlag_i = 1; recoverPC_i = 32'h3000; flagRecoverEX_i = 1; targetAddrEX_i = 32'h7000;
    tick(); chk("rec_pc", pc_o, 32'h3000); chk("rec_valid", fetchValid_o, 0);
    clr_redir(); fetchReady_i = 1;
    exceptionFlag_i = 1; exceptionPC_i = 32'h4440; flagRecoverEX_i = 1; flagRecoverID_i = 1; targetAddrID_i = 32'h1230;
    tick(); chk("exc_pc", pc_o, 32'h4440);
    exceptionFlag_i = 0;
    tick(); chk("ex_pc", pc_o, 32'h7000);
    flagRecoverEX_i = 0; flagRtrID_i = 1; rasTopCP_i = 32'h6660;
    tick(); chk("id_rtr_pc", pc_o, 32'h6660);
    flagRtrID_i = 0;
    tick(); chk("id_pc", pc_o, 32'h1230);
    clr_redir(); icMiss_i = 1;
    tick(); icMiss_i = 0;
    recover(32'h2000); chk("abort_pc", pc_o, 32'h2000);
    tick(); chk("abort_fpc", fetchPC_o, 32'h2000); chk("abort_valid", fetchValid_o, 1);
    recover(32'hFFFF_FFF0);
    tick(); chk("wrap_fpc", fetchPC_o, 32'hFFFF_FFF0);
`ifdef FETCH_ALIGN_EN
    chk("wrap_pc", pc_o, 32'h0);
`else
    chk("wrap_pc", pc_o, 32'h10);
`endif
    recover(32'h130); set_slot(3, 2'b10, 32'h900, 0);
    tick();
`ifdef FETCH_ALIGN_EN
    chk("align_mask", fetchMask_o, 4'b0011); chk("align_pc", pc_o, 32'h140); chk("align_slot", takenSlot_o, NONE);
`else
    chk("noalign_mask", fetchMask_o, 4'b1111); chk("noalign_pc", pc_o, 32'h900); chk("noalign_slot", takenSlot_o, 3);
`endif
    clr_hits();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
